// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared fetch-stage types and constants (state enum, NOP word,
//               word size, word-alignment helper).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~(WORD_BYTES - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry instruction+PC holding buffer for a stalled fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] held_data,
    output logic [31:0] held_pc
);

    logic        r_valid;
    logic [31:0] r_data;
    logic [31:0] r_pc;

    // Clear wins so a redirect always empties the entry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid <= 1'b0;
            r_data  <= NOP_INSTR;
            r_pc    <= 32'h0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
            r_pc    <= load_pc;
        end
    end

    assign valid     = r_valid;
    assign held_data = r_data;
    assign held_pc   = r_pc;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage: owns the PC, fetches over a ready
//               handshake, delivers IR/IR_VALID/IR_PC to decode and PC+4.
//               Optional macro FETCH_TIMEOUT_EN adds a sticky fetch timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    input  logic        IM_RDY,
    input  logic [31:0] IM_DATA,
    output logic        IM_REQ,
    output logic [31:0] IM_ADDR,
    output logic [31:0] IR,
    output logic        IR_VALID,
    output logic [31:0] IR_PC,
    output logic [31:0] PC_NEXT,
    output logic        FETCH_ERR
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_ir;
    logic         r_ir_valid;
    logic [31:0]  r_ir_pc;
    logic         r_im_req;
    logic         r_fetch_err;

    logic [31:0]  w_pc_next;
    logic [31:0]  w_br_pc;
    logic         w_redirect;
    logic         w_skid_load;
    logic         w_skid_clear;
    logic         w_skid_valid;
    logic [31:0]  w_skid_data;
    logic [31:0]  w_skid_pc;
    logic         w_timeout;

    assign w_pc_next    = r_pc + WORD_BYTES;
    assign w_br_pc      = word_align(BR_TARGET);
    assign w_redirect   = BR_TAKEN && ((r_state == FETCH) || (r_state == HOLD));
    assign w_skid_load  = (r_state == FETCH) && !BR_TAKEN && IM_RDY && STALL;
    assign w_skid_clear = w_redirect || ((r_state == HOLD) && !STALL);

    fetch_skid_buf u_skid (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .load      (w_skid_load),
        .clear     (w_skid_clear),
        .load_data (IM_DATA),
        .load_pc   (r_pc),
        .valid     (w_skid_valid),
        .held_data (w_skid_data),
        .held_pc   (w_skid_pc)
    );

`ifdef FETCH_TIMEOUT_EN
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_inc;
    logic             w_waiting;

    assign w_waiting  = (r_state == FETCH) && !BR_TAKEN && !IM_RDY;
    assign w_wait_inc = r_wait_cnt + CNT_W'(1);
    assign w_timeout  = w_waiting && (w_wait_inc == CNT_W'(MAX_WAIT));

    // Counts consecutive unanswered request cycles; any other cycle restarts it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_waiting ? w_wait_inc : '0;
        end
    end
`else
    logic [CNT_W-1:0] w_unused_wait;
    assign w_unused_wait = CNT_W'(MAX_WAIT);
    assign w_timeout     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= IDLE;
            r_pc        <= word_align(RESET_PC);
            r_ir        <= NOP_INSTR;
            r_ir_valid  <= 1'b0;
            r_ir_pc     <= 32'h0;
            r_im_req    <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state  <= FETCH;
                    r_im_req <= 1'b1;
                end
                FETCH: begin
                    if (BR_TAKEN) begin
                        r_pc       <= w_br_pc;
                        r_ir_valid <= 1'b0;
                    end else if (IM_RDY) begin
                        r_pc <= w_pc_next;
                        if (STALL) begin
                            r_state  <= HOLD;
                            r_im_req <= 1'b0;
                        end else begin
                            r_ir       <= IM_DATA;
                            r_ir_pc    <= r_pc;
                            r_ir_valid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state     <= ERR;
                        r_im_req    <= 1'b0;
                        r_ir_valid  <= 1'b0;
                        r_fetch_err <= 1'b1;
                    end else if (!STALL) begin
                        r_ir_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (BR_TAKEN) begin
                        r_pc       <= w_br_pc;
                        r_ir_valid <= 1'b0;
                        r_state    <= FETCH;
                        r_im_req   <= 1'b1;
                    end else if (!STALL && w_skid_valid) begin
                        r_ir       <= w_skid_data;
                        r_ir_pc    <= w_skid_pc;
                        r_ir_valid <= 1'b1;
                        r_state    <= FETCH;
                        r_im_req   <= 1'b1;
                    end
                end
                ERR: begin
                    r_im_req    <= 1'b0;
                    r_ir_valid  <= 1'b0;
                    r_fetch_err <= 1'b1;
                end
                default: begin
                    r_state  <= IDLE;
                    r_im_req <= 1'b0;
                end
            endcase
        end
    end

    assign IM_REQ    = r_im_req;
    assign IM_ADDR   = r_pc;
    assign IR        = r_ir;
    assign IR_VALID  = r_ir_valid;
    assign IR_PC     = r_ir_pc;
    assign PC_NEXT   = w_pc_next;
    assign FETCH_ERR = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Scoreboard bench for if_fetch_unit with a program-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        STALL;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic        IM_RDY;
    logic [31:0] IM_DATA;
    logic        IM_REQ;
    logic [31:0] IM_ADDR;
    logic [31:0] IR;
    logic        IR_VALID;
    logic [31:0] IR_PC;
    logic [31:0] PC_NEXT;
    logic        FETCH_ERR;

    if_fetch_unit dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .STALL     (STALL),
        .BR_TAKEN  (BR_TAKEN),
        .BR_TARGET (BR_TARGET),
        .IM_RDY    (IM_RDY),
        .IM_DATA   (IM_DATA),
        .IM_REQ    (IM_REQ),
        .IM_ADDR   (IM_ADDR),
        .IR        (IR),
        .IR_VALID  (IR_VALID),
        .IR_PC     (IR_PC),
        .PC_NEXT   (PC_NEXT),
        .FETCH_ERR (FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hE3A0_0001;
    endfunction

    assign IM_DATA = mem(IM_ADDR);

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          n_consumed = 0;
    int          lowrun     = 0;
    bit          chk_en     = 1'b1;
    bit          active     = 1'b0;
    bit          holding    = 1'b0;
    logic [31:0] exp_pc     = 32'h0;
    logic [63:0] sb[$];
    logic [63:0] mon_e;
    bit          rs, rr, rb;
    logic [31:0] rt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Program-order reference: every word fetched is queued in order until
    // decode takes it; a redirect squashes everything not yet taken.
    always @(posedge CLK) begin
        if (!RST_N) begin
            active  = 1'b0;
            holding = 1'b0;
            exp_pc  = 32'h0;
            sb.delete();
        end else if (chk_en) begin
            if (!active) begin
                active = 1'b1;
            end else if (BR_TAKEN) begin
                sb.delete();
                exp_pc  = BR_TARGET & 32'hFFFF_FFFC;
                holding = 1'b0;
            end else if (holding) begin
                if (!STALL) holding = 1'b0;
            end else if (IM_RDY) begin
                sb.push_back({exp_pc, mem(exp_pc)});
                exp_pc = exp_pc + 32'd4;
                if (STALL) holding = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (RST_N && chk_en) begin
            check("im_req", 32'(IM_REQ), 32'(active && !holding));
            check("im_addr", IM_ADDR, exp_pc);
            check("pc_next", PC_NEXT, exp_pc + 32'd4);
            check("fetch_err", 32'(FETCH_ERR), 32'd0);
            if (IR_VALID && !STALL) begin
                n_consumed++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ir_unexpected: got IR_PC %h with nothing expected", IR_PC);
                end else begin
                    mon_e = sb.pop_front();
                    check("ir_pc", IR_PC, mon_e[63:32]);
                    check("ir", IR, mon_e[31:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit s, input bit r, input bit b, input logic [31:0] t);
        STALL     = s;
        IM_RDY    = r;
        BR_TAKEN  = b;
        BR_TARGET = t;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_im_req"}, 32'(IM_REQ), 32'd0);
        check({tag, "_ir_valid"}, 32'(IR_VALID), 32'd0);
        check({tag, "_ir"}, IR, 32'h0);
        check({tag, "_ir_pc"}, IR_PC, 32'h0);
        check({tag, "_im_addr"}, IM_ADDR, 32'h0);
        check({tag, "_fetch_err"}, 32'(FETCH_ERR), 32'd0);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            rs = ($urandom_range(0, 9) < 3);
            rr = ($urandom_range(0, 9) < 7) || (lowrun >= 8);
            rb = ($urandom_range(0, 99) < 3);
            lowrun = rr ? 0 : lowrun + 1;
            rt = $urandom();
            if ($urandom_range(0, 7) == 0) rt = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
            drive(rs, rr, rb, rt);
            cyc();
        end
    endtask

    initial begin
        RST_N = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        cyc();
        cyc();
        check_reset_outputs("reset");
        check("reset_pc_next", PC_NEXT, 32'h4);
        RST_N = 1'b1;

        cyc();
        check("first_addr", IM_ADDR, 32'h0);
        cyc();
        check("first_valid", 32'(IR_VALID), 32'd1);
        check("first_ir_pc", IR_PC, 32'h0);
        check("first_ir", IR, 32'hE3A0_0001);
        cyc();

        // Three stall cycles while the word at 8 is being returned.
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        cyc();
        cyc();
        check("stall_ir_pc", IR_PC, 32'h4);
        check("stall_ir", IR, mem(32'h4));
        cyc();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        cyc();
        check("unstall_ir_pc", IR_PC, 32'h8);
        check("unstall_ir", IR, mem(32'h8));
        check("unstall_addr", IM_ADDR, 32'hC);
        cyc();
        cyc();

        // Redirect while stalled with the skid occupied.
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        cyc();
        cyc();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        cyc();
        check("br_addr", IM_ADDR, 32'h100);
        check("br_valid", 32'(IR_VALID), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        cyc();
        check("br_first_ir_pc", IR_PC, 32'h100);
        check("br_first_valid", 32'(IR_VALID), 32'd1);

        // Address wrap at the top of the 32-bit space.
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        cyc();
        check("wrap_addr", IM_ADDR, 32'hFFFF_FFFC);
        check("wrap_pc_next", PC_NEXT, 32'h0);
        cyc();
        check("wrap_after", IM_ADDR, 32'h0);

        random_run(3000);

        // Asynchronous reset in the middle of a HOLD.
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        cyc();
        cyc();
        #1 RST_N = 1'b0;
        #1;
        check_reset_outputs("async");
        cyc();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        RST_N = 1'b1;
        cyc();
        check("restart_addr", IM_ADDR, 32'h0);
        check("restart_req", 32'(IM_REQ), 32'd1);

        random_run(800);

`ifdef FETCH_TIMEOUT_EN
        chk_en = 1'b0;
        RST_N  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        RST_N = 1'b1;
        repeat (15) cyc();
        check("to_before", 32'(FETCH_ERR), 32'd0);
        cyc();
        check("to_set", 32'(FETCH_ERR), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 32'h40);
        cyc();
        cyc();
        check("to_sticky", 32'(FETCH_ERR), 32'd1);
        check("to_req", 32'(IM_REQ), 32'd0);
        check("to_valid", 32'(IR_VALID), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        RST_N = 1'b0;
        #1;
        check("to_cleared", 32'(FETCH_ERR), 32'd0);
        cyc();
        RST_N  = 1'b1;
        chk_en = 1'b1;
        random_run(200);
`endif

        n_checks++;
        if (n_consumed < 500) begin
            n_fail++;
            $display("FAIL consumed: got %0d instructions, required at least 500", n_consumed);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
